// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one external combinational ALU between two requesters.
//   Requests are accepted over per-requester valid/ready channels and
//   arbitrated round-robin. The accepted operands are registered toward the
//   ALU, and the ALU result/flags are registered back to the owner. A
//   three-state sequencer (IDLE -> EXEC -> RESP) serialises operations.
//
//   Optional feature (define ALU_SHARE_ARB_GRANT_CNT_EN):
//     per-requester 16-bit wrapping counters of completed request handshakes.
//
// Ports
//   clk, rst_n                   clock (rising edge), async active-low reset
//   req_valid[1:0]/req_ready     request channel, bit i = requester i
//   req_op_a0/b0, req_ctrl0      requester 0 operands and op (00 add,01 sub,10 and,11 or)
//   req_op_a1/b1, req_ctrl1      requester 1 operands and op
//   rsp_valid[1:0]/rsp_ready     response channel, bit i = requester i
//   rsp_result, rsp_flags        shared response payload, flags {N,Z,C,V}
//   alu_op_a/b, alu_ctrl         registered operands toward the ALU
//   alu_result, alu_flags        combinational ALU outputs
//   grant_cnt0/1                 handshake counters (optional feature only)
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req_op_a0,
  input  logic [N-1:0] req_op_b0,
  input  logic [1:0]   req_ctrl0,
  input  logic [N-1:0] req_op_a1,
  input  logic [N-1:0] req_op_b1,
  input  logic [1:0]   req_ctrl1,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic [N-1:0] alu_op_a,
  output logic [N-1:0] alu_op_b,
  output logic [1:0]   alu_ctrl,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
  ,
  output logic [15:0]  grant_cnt0,
  output logic [15:0]  grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   owner;       // requester whose operation is in flight
  logic   last_grant;  // most recent winner; loses the next tie
  logic   grant;       // candidate winner this cycle
  logic   grant_vld;   // at least one requester is asking
  logic   accept;      // request handshake this cycle

  // Round-robin pick: a lone requester wins outright, a tie goes to the
  // requester that did not win last time.
  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant     = 1'b0;
    grant_vld = 1'b0;
    case (req_valid)
      2'b01:   begin grant = 1'b0;        grant_vld = 1'b1; end
      2'b10:   begin grant = 1'b1;        grant_vld = 1'b1; end
      2'b11:   begin grant = ~last_grant; grant_vld = 1'b1; end
      default: ;
    endcase
  end

  // Sequencer next-state and handshake outputs. The granted requester is
  // valid by construction, so offering ready to it is the handshake.
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_nxt        = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  // NOTE: all state here is a handful of flops, so every register is reset;
  // an in-flight operation is simply dropped when rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      alu_op_a   <= '0;
      alu_op_b   <= '0;
      alu_ctrl   <= 2'b00;
      rsp_result <= '0;
      rsp_flags  <= 4'b0000;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= grant;
        last_grant <= grant;
        alu_op_a   <= grant ? req_op_a1 : req_op_a0;
        alu_op_b   <= grant ? req_op_b1 : req_op_b0;
        alu_ctrl   <= grant ? req_ctrl1 : req_ctrl0;
      end
      // ALU inputs have been stable from registers for the whole EXEC cycle.
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
      end
    end
  end

`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
  // Completed request handshakes per requester; 16-bit wrap is intended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= 16'h0000;
      grant_cnt1 <= 16'h0000;
    end else if (accept) begin
      if (grant) grant_cnt1 <= grant_cnt1 + 16'h0001;
      else       grant_cnt0 <= grant_cnt0 + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Self-checking bench for alu_share_arbiter. Provides a combinational ALU,
//   a transaction-level reference model (busy flag + cycles since handshake),
//   a per-cycle compare process, directed scenarios with literal expectations,
//   and a randomized phase. Define ALU_SHARE_ARB_GRANT_CNT_EN to also cover
//   the grant counters.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0] req_op_a0, req_op_b0, req_op_a1, req_op_b1;
  logic [1:0]   req_ctrl0, req_ctrl1, alu_ctrl;
  logic [N-1:0] rsp_result, alu_op_a, alu_op_b, alu_result;
  logic [3:0]   rsp_flags, alu_flags;
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
  logic [15:0]  grant_cnt0, grant_cnt1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op_a0  (req_op_a0),
    .req_op_b0  (req_op_b0),
    .req_ctrl0  (req_ctrl0),
    .req_op_a1  (req_op_a1),
    .req_op_b1  (req_op_b1),
    .req_ctrl1  (req_ctrl1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .alu_op_a   (alu_op_a),
    .alu_op_b   (alu_op_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags)
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  // Bench ALU: returns {flags[3:0] = {neg, zero, carry, overflow}, result}.
  // Subtraction carry is "no borrow" (a >= b unsigned).
  function automatic logic [N+3:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [1:0] c);
    logic [N:0]   wide;
    logic [N-1:0] r;
    logic         cy, ov;
    wide = '0; r = '0; cy = 1'b0; ov = 1'b0;
    case (c)
      2'b00: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[N-1:0];
        cy   = wide[N];
        ov   = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      2'b01: begin
        r  = a - b;
        cy = (a >= b);
        ov = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {r[N-1], (r == '0), cy, ov, r};
  endfunction

  assign {alu_flags, alu_result} = alu_fn(alu_op_a, alu_op_b, alu_ctrl);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tie goes to whoever did not win last; otherwise the lone requester wins.
  function automatic logic [1:0] grant_vec(input logic [1:0] v, input bit last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  bit           m_busy, m_owner, m_last;
  int           m_age;            // clock edges since the accepting edge
  logic [N-1:0] m_a, m_b;
  logic [1:0]   m_c;
  logic [15:0]  m_cnt0, m_cnt1;
  int           preload_seq  = 0; // written by stimulus only
  int           preload_seen = 0; // written by model only

  always @(posedge clk or negedge rst_n) begin
    logic [1:0] g;
    if (!rst_n) begin
      m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_age = 0;
      m_a = '0; m_b = '0; m_c = 2'b00; m_cnt0 = 16'h0; m_cnt1 = 16'h0;
    end else begin
      if (preload_seq != preload_seen) begin
        m_cnt0       = 16'hFFFE;
        preload_seen = preload_seq;
      end
      if (m_busy) begin
        if (m_age >= 2) begin
          if (rsp_ready[m_owner]) m_busy = 1'b0;
        end else begin
          m_age++;
        end
      end else begin
        g = grant_vec(req_valid, m_last);
        if (g != 2'b00) begin
          m_owner = g[1]; m_last = g[1]; m_busy = 1'b1; m_age = 1;
          m_a = g[1] ? req_op_a1 : req_op_a0;
          m_b = g[1] ? req_op_b1 : req_op_b0;
          m_c = g[1] ? req_ctrl1 : req_ctrl0;
          if (g[1]) m_cnt1++; else m_cnt0++;
        end
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    logic [1:0]   exp_rr, exp_rv;
    logic [N+3:0] exp_alu;
    if (rst_n) begin
      exp_rr = m_busy ? 2'b00 : grant_vec(req_valid, m_last);
      exp_rv = (m_busy && m_age >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      check("m_req_ready", req_ready, exp_rr);
      check("m_rsp_valid", rsp_valid, exp_rv);
      check("m_alu_op_a", alu_op_a, m_a);
      check("m_alu_op_b", alu_op_b, m_b);
      check("m_alu_ctrl", alu_ctrl, m_c);
      if (exp_rv != 2'b00) begin
        exp_alu = alu_fn(m_a, m_b, m_c);
        check("m_rsp_result", rsp_result, exp_alu[N-1:0]);
        check("m_rsp_flags", rsp_flags, exp_alu[N+3:N]);
      end
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
      if (preload_seq == preload_seen) begin
        check("m_grant_cnt0", grant_cnt0, m_cnt0);
        check("m_grant_cnt1", grant_cnt1, m_cnt1);
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a non-zero req_ready at a falling edge.
  task automatic wait_grant(input string name);
    int n = 0;
    @(negedge clk);
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, (req_ready != 2'b00), 1'b1);
  endtask

  logic [1:0] glog[$];
  int         gtime[$];
  logic [15:0] saved_cnt1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req_op_a0 = '0; req_op_b0 = '0; req_ctrl0 = 2'b00;
    req_op_a1 = '0; req_op_b1 = '0; req_ctrl1 = 2'b00;
    saved_cnt1 = 16'h0;
    #12;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_result", rsp_result, 32'h0);
    check("rst_rsp_flags", rsp_flags, 4'h0);
    check("rst_alu_op_a", alu_op_a, 32'h0);
    check("rst_alu_op_b", alu_op_b, 32'h0);
    check("rst_alu_ctrl", alu_ctrl, 2'b00);
    tick();
    rst_n = 1'b1;

    // A: lone requester 0, 5 + 3.
    tick();
    req_valid = 2'b01; req_op_a0 = 32'd5; req_op_b0 = 32'd3; req_ctrl0 = 2'b00; rsp_ready = 2'b01;
    @(negedge clk); check("a_req_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    @(negedge clk);
    check("a_exec_ready", req_ready, 2'b00);
    check("a_exec_valid", rsp_valid, 2'b00);
    @(negedge clk);
    check("a_rsp_valid", rsp_valid, 2'b01);
    check("a_rsp_result", rsp_result, 32'd8);
    check("a_rsp_flags", rsp_flags, 4'b0000);
    tick();
    @(negedge clk); check("a_done_valid", rsp_valid, 2'b00);

    // B: lone requester 1, 3 - 5, response back-pressured for 4 cycles while
    // requester 0 waits and asserts rsp_ready on the non-owner bit.
    tick();
    req_valid = 2'b10; req_op_a1 = 32'd3; req_op_b1 = 32'd5; req_ctrl1 = 2'b01; rsp_ready = 2'b00;
    @(negedge clk); check("b_req_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b01; rsp_ready = 2'b01;
    @(negedge clk); check("b_exec_ready", req_ready, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b_hold_valid", rsp_valid, 2'b10);
      check("b_hold_result", rsp_result, 32'hFFFF_FFFE);
      check("b_hold_flags", rsp_flags, 4'b1000);
      check("b_hold_ready", req_ready, 2'b00);
    end
    tick(); req_valid = 2'b00; rsp_ready = 2'b10;
    @(negedge clk); check("b_last_valid", rsp_valid, 2'b10);
    tick();
    @(negedge clk); check("b_done_valid", rsp_valid, 2'b00);

    // C: both requesting continuously -> alternating grants every 3 cycles.
    tick();
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_op_a0 = $urandom; req_op_b0 = $urandom; req_ctrl0 = 2'($urandom);
    req_op_a1 = $urandom; req_op_b1 = $urandom; req_ctrl1 = 2'($urandom);
    for (int i = 0; i < 40 && glog.size() < 6; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        glog.push_back(req_ready);
        gtime.push_back(i);
      end
    end
    tick(); req_valid = 2'b00;
    check("c_grant_count", glog.size(), 6);
    for (int k = 0; k < glog.size(); k++) begin
      check("c_grant_order", glog[k], (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) check("c_interval", gtime[k] - gtime[k-1], 3);
    end
    repeat (4) tick();

    // D: overflow add; operand input changes after the handshake are ignored.
    req_valid = 2'b01; req_op_a0 = 32'h7FFF_FFFF; req_op_b0 = 32'd1; req_ctrl0 = 2'b00;
    rsp_ready = 2'b00;
    @(negedge clk); check("d_req_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00; req_op_a0 = $urandom; req_op_b0 = $urandom;
    @(negedge clk);
    @(negedge clk);
    check("d_rsp_valid", rsp_valid, 2'b01);
    check("d_rsp_result", rsp_result, 32'h8000_0000);
    check("d_rsp_flags", rsp_flags, 4'b1001);
    check("d_alu_op_a", alu_op_a, 32'h7FFF_FFFF);
    tick();
    @(negedge clk);
    check("d_hold_result", rsp_result, 32'h8000_0000);
    check("d_hold_flags", rsp_flags, 4'b1001);
    tick(); rsp_ready = 2'b01;
    repeat (2) tick();

    // E: reset during EXEC, then during RESP; each time requester 0 wins the tie after.
    req_valid = 2'b01; req_op_a0 = $urandom; rsp_ready = 2'b00;
    @(negedge clk); check("e_req_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    check("e_exec_rst_valid", rsp_valid, 2'b00);
    check("e_exec_rst_ready", req_ready, 2'b00);
    check("e_exec_rst_op_a", alu_op_a, 32'h0);
    tick(); rst_n = 1'b1; req_valid = 2'b11;
    @(negedge clk); check("e_tie_after_exec_rst", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk); check("e_resp_valid", rsp_valid, 2'b01);
    #1 rst_n = 1'b0;
    #1;
    check("e_resp_rst_valid", rsp_valid, 2'b00);
    check("e_resp_rst_result", rsp_result, 32'h0);
    check("e_resp_rst_flags", rsp_flags, 4'h0);
    tick(); rst_n = 1'b1; req_valid = 2'b11;
    @(negedge clk); check("e_tie_after_resp_rst", req_ready, 2'b01);
    tick(); req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (4) tick();

    // Randomized traffic checked cycle by cycle by the model.
    for (int i = 0; i < 500; i++) begin
      req_valid = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
      req_op_a0 = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
      req_op_b0 = ($urandom_range(0, 7) == 0) ? req_op_a0 : $urandom;
      req_ctrl0 = 2'($urandom);
      req_op_a1 = $urandom; req_op_b1 = $urandom; req_ctrl1 = 2'($urandom);
      tick();
    end
    req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (4) tick();

`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
    // Counter wrap: preload 0xFFFE on requester 0, then two more grants.
    saved_cnt1 = m_cnt1;
    force dut.grant_cnt0 = 16'hFFFE;
    preload_seq++;
    #1 release dut.grant_cnt0;
    for (int k = 0; k < 2; k++) begin
      tick(); req_valid = 2'b01; rsp_ready = 2'b01;
      wait_grant("f_grant");
      tick(); req_valid = 2'b00;
      repeat (3) tick();
    end
    check("f_grant_cnt0_wrap", grant_cnt0, 16'h0000);
    check("f_grant_cnt1_same", grant_cnt1, saved_cnt1);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
